fetch_unit: RTL and testbench

//  IF stage plus IF/ID pipeline register: owns the PC, drives the instruction-memory address, registers the fetched word.
//  Pre-decodes each fetched word into the 6-bit instruction code consumed by the decode stage.

---
 rtl/fetch_unit_pkg.sv | 43 ++++
 rtl/fetch_unit_predecode.sv | 43 ++++
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared instruction definitions for the fetch stage and the control unit:
// MIPS opcode/funct values, the 6-bit pre-decoded instruction codes,
// the default reset PC and the fetch FSM state type.
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL function codes (instr[5:0])
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;

    // Pre-decoded instruction codes handed to the decode stage
    localparam logic [5:0] CODE_NOP     = 6'd0;
    localparam logic [5:0] CODE_ADDU    = 6'd1;
    localparam logic [5:0] CODE_SUBU    = 6'd2;
    localparam logic [5:0] CODE_ORI     = 6'd3;
    localparam logic [5:0] CODE_LW      = 6'd4;
    localparam logic [5:0] CODE_SW      = 6'd5;
    localparam logic [5:0] CODE_BEQ     = 6'd6;
    localparam logic [5:0] CODE_LUI     = 6'd7;
    localparam logic [5:0] CODE_J       = 6'd8;
    localparam logic [5:0] CODE_JAL     = 6'd9;
    localparam logic [5:0] CODE_JR      = 6'd10;
    localparam logic [5:0] CODE_UNKNOWN = 6'h3F;

    // RUN: normal fetch. WAIT_DS: redirect latched, still waiting for the delay slot word.
    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_WAIT_DS = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_predecode.sv
// Combinational pre-decoder: maps a raw 32-bit instruction word onto the
// 6-bit instruction code used by the decode stage.
module instr_predecode
    import fetch_unit_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  code
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];

    // All-zero word is the canonical nop; otherwise classify by opcode, then funct for SPECIAL
    always_comb begin
        code = CODE_UNKNOWN;
        if (instr == 32'h0000_0000) begin
            code = CODE_NOP;
        end else begin
            case (opcode)
                OP_SPECIAL: begin
                    case (funct)
                        FN_ADDU: code = CODE_ADDU;
                        FN_SUBU: code = CODE_SUBU;
                        FN_JR:   code = CODE_JR;
                        default: code = CODE_UNKNOWN;
                    endcase
                end
                OP_ORI:  code = CODE_ORI;
                OP_LW:   code = CODE_LW;
                OP_SW:   code = CODE_SW;
                OP_BEQ:  code = CODE_BEQ;
                OP_LUI:  code = CODE_LUI;
                OP_J:    code = CODE_J;
                OP_JAL:  code = CODE_JAL;
                default: code = CODE_UNKNOWN;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage plus IF/ID pipeline register. Owns the PC, fetches from
// instruction memory, pre-decodes the fetched word and resolves
// branch/jump/jr redirects with a single MIPS delay slot.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_in,
    input  logic [31:0] branch_addr_in,
    input  logic        jump_in,
    input  logic [25:0] jump_addr_in,
    input  logic        jump_reg_in,
    input  logic [31:0] jump_reg_addr_in,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc_out,
    output logic [31:0] instructure_out,
    output logic [5:0]  instr_code_out,
    output logic        valid_out
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  tgt_q;
    logic [31:0]  pc_plus4;
    logic [31:0]  ds_pc;
    logic [31:0]  redirect_target;
    logic         redirect_ok;
    logic         redirect_take;
    logic [5:0]   fetched_code;
    logic         ifid_load;
    logic         ifid_bubble;

    instr_predecode u_predecode (
        .instr (imem_rdata),
        .code  (fetched_code)
    );

    assign imem_addr = pc_q;
    assign pc_plus4  = pc_q + 32'd4;

    // The delay slot sits right behind the instruction in decode; targets are relative to it
    assign ds_pc = pc_out + 32'd4;

    // Decode may only redirect while it holds a real instruction and nothing is pending
    assign redirect_ok   = valid_out && !stall && (state_q == ST_RUN);
    assign redirect_take = redirect_ok && (jump_reg_in || jump_in || branch_in);

    // Next-target mux, jr has highest priority, then j/jal, then taken branch
    always_comb begin
        redirect_target = ds_pc + (branch_addr_in << 2);
        if (jump_in) begin
            redirect_target = {ds_pc[31:28], jump_addr_in, 2'b00};
        end
        if (jump_reg_in) begin
            redirect_target = jump_reg_addr_in;
        end
    end

    // IF/ID update rule is the same in both FSM states; flush beats stall
    assign ifid_load   = !flush && !stall && imem_ready;
    assign ifid_bubble = flush || (!stall && !imem_ready);

    // PC, latched redirect target and FSM state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            tgt_q   <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!stall) begin
                        if (imem_ready) begin
                            pc_q <= redirect_take ? redirect_target : pc_plus4;
                        end else if (redirect_take) begin
                            tgt_q   <= redirect_target;
                            state_q <= ST_WAIT_DS;
                        end
                    end
                end
                ST_WAIT_DS: begin
                    if (!stall && imem_ready) begin
                        pc_q    <= tgt_q;
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    // IF/ID pipeline register: capture the fetched word, insert a bubble, or hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out          <= 32'h0000_0000;
            instructure_out <= 32'h0000_0000;
            instr_code_out  <= CODE_NOP;
            valid_out       <= 1'b0;
        end else if (ifid_load) begin
            pc_out          <= pc_q;
            instructure_out <= imem_rdata;
            instr_code_out  <= fetched_code;
            valid_out       <= 1'b1;
        end else if (ifid_bubble) begin
            instructure_out <= 32'h0000_0000;
            instr_code_out  <= CODE_NOP;
            valid_out       <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: small instruction-memory model,
// hand-computed expected addresses and IF/ID contents.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_in;
    logic [31:0] branch_addr_in;
    logic        jump_in;
    logic [25:0] jump_addr_in;
    logic        jump_reg_in;
    logic [31:0] jump_reg_addr_in;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc_out;
    logic [31:0] instructure_out;
    logic [5:0]  instr_code_out;
    logic        valid_out;

    int error_count = 0;
    int check_count = 0;

    localparam logic [31:0] W_BEQ  = 32'h1000_0003;
    localparam logic [31:0] W_ORI  = 32'h3421_0001;
    localparam logic [31:0] W_LW   = 32'h8C22_0004;
    localparam logic [31:0] W_ADDU = 32'h0022_1821;
    localparam logic [31:0] W_JR   = 32'h03E0_0008;
    localparam logic [31:0] W_UNK  = 32'hFC00_0000;

    fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .flush            (flush),
        .branch_in        (branch_in),
        .branch_addr_in   (branch_addr_in),
        .jump_in          (jump_in),
        .jump_addr_in     (jump_addr_in),
        .jump_reg_in      (jump_reg_in),
        .jump_reg_addr_in (jump_reg_addr_in),
        .imem_addr        (imem_addr),
        .imem_rdata       (imem_rdata),
        .imem_ready       (imem_ready),
        .pc_out           (pc_out),
        .instructure_out  (instructure_out),
        .instr_code_out   (instr_code_out),
        .valid_out        (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model
    always_comb begin
        case (imem_addr)
            32'h0000_3000: imem_rdata = W_BEQ;
            32'h0000_3004: imem_rdata = W_ORI;
            32'h0000_3008: imem_rdata = 32'h0000_0000;
            32'h0000_3010: imem_rdata = W_LW;
            32'h0000_3014: imem_rdata = W_ADDU;
            32'h0000_3100: imem_rdata = W_JR;
            default:       imem_rdata = W_UNK;
        endcase
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the rising edge
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clearInputs();
        stall            = 1'b0;
        flush            = 1'b0;
        branch_in        = 1'b0;
        branch_addr_in   = 32'h0;
        jump_in          = 1'b0;
        jump_addr_in     = 26'h0;
        jump_reg_in      = 1'b0;
        jump_reg_addr_in = 32'h0;
        imem_ready       = 1'b1;
    endtask

    // Reset, check reset state, release mid-cycle, then take the first fetch of 0x3000
    task automatic resetAndFirstFetch(input string tag);
        clearInputs();
        reset = 1'b1;
        applyStimulus(1);
        checkOutput({tag, "_rst_addr"},  imem_addr, 32'h0000_3000);
        checkOutput({tag, "_rst_valid"}, {31'b0, valid_out}, 32'h0);
        reset = 1'b0;
        applyStimulus(1);
        checkOutput({tag, "_first_pc"}, pc_out, 32'h0000_3000);
    endtask

    initial begin
        clearInputs();
        reset = 1'b1;
        #2;

        // 1: reset values and sequential fetch
        applyStimulus(1);
        checkOutput("t1_rst_pc_out", pc_out, 32'h0);
        checkOutput("t1_rst_instr", instructure_out, 32'h0);
        checkOutput("t1_rst_code", {26'b0, instr_code_out}, {26'b0, CODE_NOP});
        checkOutput("t1_rst_valid", {31'b0, valid_out}, 32'h0);
        checkOutput("t1_rst_addr", imem_addr, 32'h0000_3000);
        reset = 1'b0;
        applyStimulus(1);
        checkOutput("t1_valid_rise", {31'b0, valid_out}, 32'h1);
        checkOutput("t1_addr_3004", imem_addr, 32'h0000_3004);
        checkOutput("t1_instr_beq", instructure_out, W_BEQ);
        checkOutput("t1_code_beq", {26'b0, instr_code_out}, {26'b0, CODE_BEQ});
        applyStimulus(1);
        checkOutput("t1_addr_3008", imem_addr, 32'h0000_3008);
        checkOutput("t1_code_ori", {26'b0, instr_code_out}, {26'b0, CODE_ORI});
        applyStimulus(1);
        checkOutput("t1_pc_3008", pc_out, 32'h0000_3008);
        checkOutput("t1_code_nop", {26'b0, instr_code_out}, {26'b0, CODE_NOP});

        // 2: beq in decode, offset 3 -> target 0x3000+4+0xC = 0x3010
        resetAndFirstFetch("t2");
        branch_in      = 1'b1;
        branch_addr_in = 32'h0000_0003;
        applyStimulus(1);
        branch_in = 1'b0;
        checkOutput("t2_ds_pc", pc_out, 32'h0000_3004);
        checkOutput("t2_ds_valid", {31'b0, valid_out}, 32'h1);
        checkOutput("t2_target", imem_addr, 32'h0000_3010);
        applyStimulus(1);
        checkOutput("t2_tgt_code_lw", {26'b0, instr_code_out}, {26'b0, CODE_LW});
        checkOutput("t2_after_tgt", imem_addr, 32'h0000_3014);

        // 3: jr and j together, jr wins
        resetAndFirstFetch("t3");
        jump_reg_in      = 1'b1;
        jump_reg_addr_in = 32'h0000_3100;
        jump_in          = 1'b1;
        jump_addr_in     = 26'h000_1000;
        applyStimulus(1);
        jump_reg_in = 1'b0;
        jump_in     = 1'b0;
        checkOutput("t3_jr_wins", imem_addr, 32'h0000_3100);
        checkOutput("t3_ds_pc", pc_out, 32'h0000_3004);
        applyStimulus(1);
        checkOutput("t3_code_jr", {26'b0, instr_code_out}, {26'b0, CODE_JR});

        // 3b: j alone -> {ds_pc[31:28], idx, 00} = 0x4000
        resetAndFirstFetch("t3b");
        jump_in      = 1'b1;
        jump_addr_in = 26'h000_1000;
        applyStimulus(1);
        jump_in = 1'b0;
        checkOutput("t3b_j_target", imem_addr, 32'h0000_4000);

        // 4: redirect while imem not ready for 3 cycles
        resetAndFirstFetch("t4");
        branch_in      = 1'b1;
        branch_addr_in = 32'h0000_0003;
        imem_ready     = 1'b0;
        applyStimulus(1);
        branch_in = 1'b0;
        checkOutput("t4_bubble1", {31'b0, valid_out}, 32'h0);
        checkOutput("t4_bubble_pc", pc_out, 32'h0000_3000);
        checkOutput("t4_hold_addr", imem_addr, 32'h0000_3004);
        applyStimulus(2);
        checkOutput("t4_bubble3", {31'b0, valid_out}, 32'h0);
        checkOutput("t4_bubble_instr", instructure_out, 32'h0);
        checkOutput("t4_hold_addr3", imem_addr, 32'h0000_3004);
        imem_ready = 1'b1;
        applyStimulus(1);
        checkOutput("t4_ds_pc", pc_out, 32'h0000_3004);
        checkOutput("t4_ds_valid", {31'b0, valid_out}, 32'h1);
        checkOutput("t4_target", imem_addr, 32'h0000_3010);
        applyStimulus(1);
        checkOutput("t4_tgt_pc", pc_out, 32'h0000_3010);
        checkOutput("t4_run_again", imem_addr, 32'h0000_3014);

        // 5: stall while branch_in, then redirect once stall drops
        resetAndFirstFetch("t5");
        stall          = 1'b1;
        branch_in      = 1'b1;
        branch_addr_in = 32'h0000_0003;
        applyStimulus(2);
        checkOutput("t5_stall_addr", imem_addr, 32'h0000_3004);
        checkOutput("t5_stall_pc", pc_out, 32'h0000_3000);
        checkOutput("t5_stall_valid", {31'b0, valid_out}, 32'h1);
        stall = 1'b0;
        applyStimulus(1);
        branch_in = 1'b0;
        checkOutput("t5_ds_pc", pc_out, 32'h0000_3004);
        checkOutput("t5_target", imem_addr, 32'h0000_3010);

        // 6: async reset in WAIT_DS discards latched target
        resetAndFirstFetch("t6");
        branch_in      = 1'b1;
        branch_addr_in = 32'h0000_0003;
        imem_ready     = 1'b0;
        applyStimulus(1);
        branch_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_async_addr", imem_addr, 32'h0000_3000);
        checkOutput("t6_async_pc_out", pc_out, 32'h0);
        checkOutput("t6_async_valid", {31'b0, valid_out}, 32'h0);
        applyStimulus(1);
        imem_ready = 1'b1;
        reset      = 1'b0;
        applyStimulus(1);
        checkOutput("t6_first_pc", pc_out, 32'h0000_3000);
        checkOutput("t6_next_addr", imem_addr, 32'h0000_3004);

        // 7: flush inserts a bubble while the PC keeps advancing
        resetAndFirstFetch("t7");
        flush = 1'b1;
        applyStimulus(1);
        flush = 1'b0;
        checkOutput("t7_flush_valid", {31'b0, valid_out}, 32'h0);
        checkOutput("t7_flush_pc", pc_out, 32'h0000_3000);
        checkOutput("t7_flush_addr", imem_addr, 32'h0000_3008);
        applyStimulus(1);
        checkOutput("t7_after_pc", pc_out, 32'h0000_3008);

        // 8: jr to top of memory, PC+4 wraps to zero
        resetAndFirstFetch("t8");
        jump_reg_in      = 1'b1;
        jump_reg_addr_in = 32'hFFFF_FFFC;
        applyStimulus(1);
        jump_reg_in = 1'b0;
        checkOutput("t8_top_addr", imem_addr, 32'hFFFF_FFFC);
        applyStimulus(1);
        checkOutput("t8_wrap_addr", imem_addr, 32'h0);
        checkOutput("t8_code_unknown", {26'b0, instr_code_out}, {26'b0, CODE_UNKNOWN});

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule
